regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter and sole driver of the 32x32 register file write port.
//   Two producers (src 0 = ALU path, src 1 = load/long-latency path) hand
//   results over with valid/ready. Each source has its own circular FIFO.
//   One head per cycle is granted round-robin and issued on a registered
//   we3/a3/wd3 triple. q_pending reports whether a write to q_addr is
//   still queued or is being written this cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   s0_valid/ready/addr/data   source 0 push handshake and payload
//   s1_valid/ready/addr/data   source 1 push handshake and payload
//   we3, a3, wd3          register file write port (registered)
//   q_addr, q_pending     read-after-write hazard query (combinational)
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [4:0]  s0_addr,
  input  logic [31:0] s0_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [4:0]  s1_addr,
  input  logic [31:0] s1_data,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  input  logic [4:0]  q_addr,
  output logic        q_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    r_addr   [2][DEPTH];
  logic [31:0]   r_data   [2][DEPTH];
  logic [PW-1:0] r_wr_ptr [2];
  logic [PW-1:0] r_rd_ptr [2];
  logic [CW-1:0] r_count  [2];
  logic          r_rr;
  logic          r_we3;
  logic [4:0]    r_a3;
  logic [31:0]   r_wd3;

  logic [1:0]    w_valid;
  logic [1:0]    w_ready;
  logic [1:0]    w_push;
  logic [1:0]    w_nempty;
  logic [1:0]    w_grant;
  logic [4:0]    w_in_addr [2];
  logic [31:0]   w_in_data [2];
  logic          w_any;
  logic          w_gsrc;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic          w_hit;
  logic [PW-1:0] w_off;

  assign w_valid      = {s1_valid, s0_valid};
  assign w_in_addr[0] = s0_addr;
  assign w_in_addr[1] = s1_addr;
  assign w_in_data[0] = s0_data;
  assign w_in_data[1] = s1_data;

  // Ready is forced low during reset so nothing is handshaken that the
  // reset edge would then discard.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_ready[i]  = !rst && (r_count[i] != FULL);
      w_nempty[i] = (r_count[i] != '0);
      // x0 writes complete the handshake but are never enqueued.
      w_push[i]   = w_valid[i] && w_ready[i] && (w_in_addr[i] != 5'd0);
    end
  end

  assign s0_ready = w_ready[0];
  assign s1_ready = w_ready[1];

  // Round-robin: with both heads present rr picks; with one present it wins.
  always_comb begin
    w_any  = 1'b0;
    w_gsrc = r_rr;
    if (w_nempty[0] && w_nempty[1]) begin
      w_any  = 1'b1;
      w_gsrc = r_rr;
    end else if (w_nempty[0]) begin
      w_any  = 1'b1;
      w_gsrc = 1'b0;
    end else if (w_nempty[1]) begin
      w_any  = 1'b1;
      w_gsrc = 1'b1;
    end
    w_grant[0] = w_any && !w_gsrc;
    w_grant[1] = w_any && w_gsrc;
  end

  assign w_head_addr = r_addr[w_gsrc][r_rd_ptr[w_gsrc]];
  assign w_head_data = r_data[w_gsrc][r_rd_ptr[w_gsrc]];

  // Entry storage needs no reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_addr[i][r_wr_ptr[i]] <= w_in_addr[i];
        r_data[i][r_wr_ptr[i]] <= w_in_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_rr  <= 1'b0;
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
        if (w_grant[i]) r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        if (w_push[i] && !w_grant[i]) begin
          r_count[i] <= r_count[i] + CW'(1);
        end else if (!w_push[i] && w_grant[i]) begin
          r_count[i] <= r_count[i] - CW'(1);
        end
      end
      if (w_any) begin
        // Next priority goes to the source that did not just win.
        r_rr  <= ~w_gsrc;
        r_we3 <= 1'b1;
        r_a3  <= w_head_addr;
        r_wd3 <= w_head_data;
      end else begin
        r_we3 <= 1'b0;
      end
    end
  end

  assign we3 = r_we3;
  assign a3  = r_a3;
  assign wd3 = r_wd3;

  // A slot is live when its distance from rd_ptr (mod DEPTH) is below count.
  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        w_off = PW'(j) - r_rd_ptr[i];
        if (({1'b0, w_off} < r_count[i]) && (r_addr[i][j] == q_addr)) begin
          w_hit = 1'b1;
        end
      end
    end
    q_pending = !rst && (q_addr != 5'd0) &&
                (w_hit || (r_we3 && (r_a3 == q_addr)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_addr = '0, s1_addr = '0;
  logic [31:0] s0_data = '0, s1_data = '0;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [4:0]  q_addr = '0;
  logic        q_pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .we3(we3), .a3(a3), .wd3(wd3),
    .q_addr(q_addr), .q_pending(q_pending)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  typedef struct {
    logic        s0v; logic [4:0] s0a; logic [31:0] s0d;
    logic        s1v; logic [4:0] s1a; logic [31:0] s1d;
    logic [4:0]  qa;
    logic        e_r0; logic e_r1; logic e_we; logic [4:0] e_a3; logic [31:0] e_wd; logic e_qp;
  } vec_t;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;

  vec_t vt[14];
  ent_t exp_q0[$], exp_q1[$], log_q[$];
  bit   mon_en = 1'b0;
  bit   saw_s0_full = 1'b0;

  always @(negedge clk) if (mon_en && we3) log_q.push_back({a3, wd3});

  task automatic idle_inputs();
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_addr = '0; s1_addr = '0; s0_data = '0; s1_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1; q_addr = 5'd5;
    #1;
    chk("rst s0_ready", s0_ready, 0);
    chk("rst s1_ready", s1_ready, 0);
    chk("rst q_pending", q_pending, 0);
    @(negedge clk); #1;
    chk("rst we3", we3, 0);
    chk("rst a3", a3, 0);
    chk("rst wd3", wd3, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_src(input int src, input int n);
    logic [4:0]  a;
    logic [31:0] d;
    logic        rdy;
    int          guard;
    bit          done;
    for (int e = 0; e < n; e++) begin
      a = (src != 0) ? 5'(16 + e) : 5'(1 + e);
      d = (src != 0) ? (32'hB100_0000 + 32'(e)) : (32'hB000_0000 + 32'(e));
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (src == 0) begin s0_valid = 1'b1; s0_addr = a; s0_data = d; end
        else          begin s1_valid = 1'b1; s1_addr = a; s1_data = d; end
        #1;
        rdy = (src == 0) ? s0_ready : s1_ready;
        if (rdy) begin
          done = 1'b1;
          if (src == 0) exp_q0.push_back({a, d});
          else          exp_q1.push_back({a, d});
        end else if (src == 0) begin
          saw_s0_full = 1'b1;
        end
        guard++;
        if (!done && guard > 50) begin
          fail_now($sformatf("bp handshake src%0d entry%0d", src, e));
          done = 1'b1;
        end
      end
    end
    @(negedge clk);
    if (src == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rst_q [7];
    ent_t       w;

    //        s0v  s0a    s0d            s1v  s1a    s1d           qa      r0    r1    we    a3     wd3            qp
    vt[0]  = '{1'b1, 5'd1, 32'h101,      1'b1, 5'd11, 32'h211,  5'd1,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0};
    vt[1]  = '{1'b1, 5'd2, 32'h102,      1'b1, 5'd12, 32'h212,  5'd1,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        1'b1};
    vt[2]  = '{1'b1, 5'd3, 32'h103,      1'b1, 5'd13, 32'h213,  5'd11, 1'b1, 1'b1, 1'b1, 5'd1,  32'h101,      1'b1};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd13, 1'b1, 1'b1, 1'b1, 5'd11, 32'h211,      1'b1};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd2,  1'b1, 1'b1, 1'b1, 5'd2,  32'h102,      1'b1};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd3,  1'b1, 1'b1, 1'b1, 5'd12, 32'h212,      1'b1};
    vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd12, 1'b1, 1'b1, 1'b1, 5'd3,  32'h103,      1'b0};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd13, 1'b1, 1'b1, 1'b1, 5'd13, 32'h213,      1'b1};
    vt[8]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    5'd13, 1'b1, 1'b1, 1'b0, 5'd13, 32'h213,      1'b0};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd5,  1'b1, 1'b1, 1'b0, 5'd13, 32'h213,      1'b1};
    vt[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd5,  1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
    vt[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  32'h1234, 5'd5,  1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
    vt[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd0,  1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
    vt[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    5'd0,  1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};

    do_reset();

    // contention, single write, x0 drop
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      s0_valid = vt[k].s0v; s0_addr = vt[k].s0a; s0_data = vt[k].s0d;
      s1_valid = vt[k].s1v; s1_addr = vt[k].s1a; s1_data = vt[k].s1d;
      q_addr   = vt[k].qa;
      #1;
      chk($sformatf("v%0d s0_ready", k), s0_ready, vt[k].e_r0);
      chk($sformatf("v%0d s1_ready", k), s1_ready, vt[k].e_r1);
      chk($sformatf("v%0d we3", k), we3, vt[k].e_we);
      chk($sformatf("v%0d a3", k), a3, vt[k].e_a3);
      chk($sformatf("v%0d wd3", k), wd3, vt[k].e_wd);
      chk($sformatf("v%0d q_pending", k), q_pending, vt[k].e_qp);
    end
    @(negedge clk);
    idle_inputs();

    // wrap-around: 10 entries through s0 at one per cycle
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 10) begin
        s0_valid = 1'b1; s0_addr = 5'(20 + k); s0_data = 32'hA000_0000 + 32'(k);
      end else begin
        s0_valid = 1'b0;
      end
      q_addr = (k >= 3) ? 5'(20 + k - 3) : 5'd20;
      #1;
      chk($sformatf("wrap%0d s0_ready", k), s0_ready, 1);
      chk($sformatf("wrap%0d we3", k), we3, 32'(k >= 2));
      if (k >= 2) begin
        chk($sformatf("wrap%0d a3", k), a3, 32'(20 + k - 2));
        chk($sformatf("wrap%0d wd3", k), wd3, 32'hA000_0000 + 32'(k - 2));
      end
      chk($sformatf("wrap%0d q_pending", k), q_pending, 32'(k == 1 || k == 2));
    end
    @(negedge clk);
    idle_inputs();

    // full / backpressure with both sources saturated
    do_reset();
    mon_en = 1'b1;
    fork
      drive_src(0, 10);
      drive_src(1, 10);
    join
    repeat (30) @(negedge clk);
    mon_en = 1'b0;
    chk("bp s0_ready seen low", 32'(saw_s0_full), 1);
    chk("bp write count", log_q.size(), 20);
    while (log_q.size() > 0) begin
      w = log_q.pop_front();
      if (w.a < 5'd16) begin
        if (exp_q0.size() == 0) fail_now("bp extra s0 write");
        else chk($sformatf("bp s0 write a%0d", w.a), w, exp_q0.pop_front());
      end else begin
        if (exp_q1.size() == 0) fail_now("bp extra s1 write");
        else chk($sformatf("bp s1 write a%0d", w.a), w, exp_q1.pop_front());
      end
    end
    chk("bp s0 leftover", exp_q0.size(), 0);
    chk("bp s1 leftover", exp_q1.size(), 0);

    // reset mid-operation
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s0_valid = 1'b1; s0_addr = 5'(21 + k); s0_data = 32'hC000_0000 + 32'(k);
      s1_valid = 1'b1; s1_addr = 5'(25 + k); s1_data = 32'hC100_0000 + 32'(k);
    end
    @(negedge clk);
    s1_valid = 1'b0;
    s0_addr = 5'd29; s0_data = 32'hDD;
    rst = 1'b1; q_addr = 5'd22;
    #1;
    chk("midrst s0_ready", s0_ready, 0);
    chk("midrst q_pending", q_pending, 0);
    rst_q = '{5'd21, 5'd22, 5'd23, 5'd25, 5'd26, 5'd27, 5'd29};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      q_addr = rst_q[k];
      #1;
      if (k == 0) begin
        chk("midrst a3", a3, 0);
        chk("midrst wd3", wd3, 0);
      end
      chk($sformatf("midrst%0d we3", k), we3, 0);
      chk($sformatf("midrst%0d q_pending", k), q_pending, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
